// File: rtl/iter_shifter_pkg.sv
// iter_shifter_pkg: shared types for the iterative shift unit.
// Mode and FSM state encodings plus an amount-width helper.
package iter_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // Bits needed to hold values 0 .. n-1 (never less than one).
  function automatic int amt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shifter_step.sv
// shifter_step: combinational shift of one word by 0..SHIFTVAL places.
// Rotate is built only with ITER_SHIFTER_ROR_EN; else mode 11 acts as SRL.
module shifter_step
  import iter_shifter_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int SHIFTVAL = 2,
  localparam int KW      = amt_w(SHIFTVAL + 1)
) (
  input  logic [SIZE-1:0] data,
  input  logic [KW-1:0]   k,
  input  mode_e           mode,
  output logic [SIZE-1:0] res
);

  // Pick the constant-distance shift matching k; k == 0 passes through.
  always_comb begin
    res = data;
    for (int i = 1; i <= SHIFTVAL; i++) begin
      if (k == KW'(i)) begin
        unique case (mode)
          MODE_SLL: res = data << i;
          MODE_SRL: res = data >> i;
          MODE_SRA: res = SIZE'($signed(data) >>> i);
          MODE_ROR: begin
`ifdef ITER_SHIFTER_ROR_EN
            res = (data >> i) | (data << (SIZE - i));
`else
            res = data >> i;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: valid/ready shift unit, up to SHIFTVAL places per clock.
// Optional rotate-right via ITER_SHIFTER_ROR_EN (mode 11 = SRL without it).
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int SHIFTVAL = 2,
  localparam int AW      = amt_w(SIZE),
  localparam int KW      = amt_w(SHIFTVAL + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic [AW-1:0]   in_amt,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data
);

  localparam logic [AW-1:0] SV_A = AW'(SHIFTVAL);

  state_e          state;
  mode_e           mode_q;
  logic [SIZE-1:0] data_q;
  logic [AW-1:0]   rem;
  logic [KW-1:0]   step_k;
  logic [SIZE-1:0] step_res;

  // Step size is min(SHIFTVAL, rem); when rem fits, it fits in KW bits.
  assign step_k = (rem > SV_A) ? KW'(SHIFTVAL) : rem[KW-1:0];

  shifter_step #(
    .SIZE     (SIZE),
    .SHIFTVAL (SHIFTVAL)
  ) u_step (
    .data (data_q),
    .k    (step_k),
    .mode (mode_q),
    .res  (step_res)
  );

  assign out_data = data_q;

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= MODE_SLL;
      data_q    <= '0;
      rem       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            mode_q   <= mode_e'(in_mode);
            rem      <= in_amt;
            in_ready <= 1'b0;
            if (in_amt == '0) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          data_q <= step_res;
          rem    <= rem - AW'(step_k);
          if (rem <= SV_A) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: randomized and directed checks of iter_shifter
// against an arithmetic reference model (honours ITER_SHIFTER_ROR_EN).
module tb_iter_shifter;

  localparam int SIZE     = 32;
  localparam int SHIFTVAL = 2;
  localparam int AW       = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_data;
  logic [AW-1:0]   in_amt;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_data;

  int checks = 0;
  int errors = 0;

  iter_shifter #(
    .SIZE     (SIZE),
    .SHIFTVAL (SHIFTVAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d,
                                        input int a, input int m);
    logic [31:0] r;
    case (m)
      0: r = d << a;
      1: r = d >> a;
      2: r = 32'($signed(d) >>> a);
      default: begin
`ifdef ITER_SHIFTER_ROR_EN
        r = (a == 0) ? d : ((d >> a) | (d << (32 - a)));
`else
        r = d >> a;
`endif
      end
    endcase
    return r;
  endfunction

  // One request; hold DONE for 'hold' cycles with a stray in_valid.
  task automatic xact(input logic [31:0] d, input int a, input int m,
                      input int hold, input string tag);
    logic [31:0] exp;
    int lat;
    int w;
    exp = model(d, a, m);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_data  = d;
    in_amt   = a[AW-1:0];
    in_mode  = m[1:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = AW'($urandom);
    in_mode  = 2'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    chk({tag, "_lat"}, lat, 1 + (a + SHIFTVAL - 1) / SHIFTVAL);
    chk({tag, "_data"}, out_data, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == hold / 2);
      in_data  = $urandom;
      in_amt   = AW'($urandom);
      @(negedge clk);
      chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_d"}, out_data, exp);
      chk({tag, "_hold_r"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_r"}, 32'(in_ready), 32'd1);
    chk({tag, "_ack_v"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    xact(32'h0000_0001, 5, 0, 0, "sll5");
    chk("sll5_const", model(32'h1, 5, 0), 32'h20);
    xact(32'h8000_0000, 31, 2, 0, "sra31");
    xact(32'h8000_0000, 31, 1, 0, "srl31");
    for (int m = 0; m < 4; m++) xact(32'h1234_5678, 0, m, 0, "amt0");
    xact(32'h0000_00F1, 4, 3, 0, "mode3");
    xact(32'hDEAD_BEEF, 7, 2, 10, "bp");

    // Reset in the middle of a long shift.
    in_data  = $urandom;
    in_amt   = 5'd20;
    in_mode  = 2'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_v", 32'(out_valid), 32'd0);
    chk("abort_rst_r", 32'(in_ready), 32'd0);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    xact(32'h0000_0003, 2, 0, 0, "post_abort");

    for (int n = 0; n < 150; n++)
      xact($urandom, int'($urandom_range(0, SIZE - 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Multi-cycle, parametrised shift unit that moves a `SIZE`-bit word by a variable amount, at most `SHIFTVAL` bit positions per clock. It supports logical-left, logical-right, arithmetic-right and (optionally) rotate-right modes. It sits on the datapath behind a valid/ready handshake, so it can be placed between producer and consumer stages that tolerate variable latency. It trades latency for area against a full barrel shifter.

## Interface
- `SIZE`, 32, data width in bits; power of two, ≥ 2.
- `SHIFTVAL`, 2, maximum bit positions shifted per cycle; 1 ≤ `SHIFTVAL` < `SIZE`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `in_data`  in  `SIZE`  operand.
- `in_amt`  in  `$clog2(SIZE)`  shift amount, 0 … `SIZE`-1.
- `in_mode`  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  `SIZE`  result.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, the block latches data, mode and remaining count `rem`=`in_amt`.
  - Next state is DONE if `in_amt`==0, otherwise SHIFT.
- SHIFT:
  - Each cycle, the block applies one step of k = min(`SHIFTVAL`, `rem`) positions in the latched mode, and sets `rem` ← `rem`−k.
  - When `rem` ≤ `SHIFTVAL`, the next state is DONE.
- DONE:
  - `out_valid`=1. `out_data` is held stable while `out_ready`=0.
  - On `out_ready`, the block returns to IDLE.
- `in_ready`=1 only in IDLE. `in_valid` is ignored in SHIFT and DONE. There is no back-to-back overlap.
- Mode semantics per step:
  - SLL fills with zeros at the LSB.
  - SRL fills with zeros at the MSB.
  - SRA replicates the latched MSB.
  - ROR moves the LSBs to the MSB.
- Result equals the single-cycle shift by `in_amt`. All arithmetic is modulo `SIZE` bits. `rem` never underflows.
- Reset values: `in_ready`=0 during reset, 1 after release (IDLE). `out_valid`=0. `out_data`=0. `rem`=0. State is IDLE.
- Reset mid-operation aborts immediately. No result is produced, and the next request starts clean.
- `in_mode` and `in_amt` are sampled only at acceptance. Changes on them afterwards have no effect.

## Timing
- Acceptance at cycle N → `out_valid` first high at cycle N+1+⌈`in_amt`/`SHIFTVAL`⌉.
  - `in_amt`=0 → N+1.
  - Worst case is N+1+⌈(`SIZE`−1)/`SHIFTVAL`⌉; for 32/2 this is N+17.
- Output handshake at cycle M → `in_ready` high at M+1.
- `out_data`, `out_valid` and `in_ready` are driven from registers or state decode only. There is no combinational path from any input.

## Configuration
- `ITER_SHIFTER_ROR_EN` defined: mode 11 performs rotate-right.
- `ITER_SHIFTER_ROR_EN` undefined: the rotate logic is not built, and mode 11 behaves exactly as SRL (01).

## Structure
- Package `iter_shifter_pkg` holds:
  - the mode encodings MODE_SLL/MODE_SRL/MODE_SRA/MODE_ROR;
  - the state encodings S_IDLE/S_SHIFT/S_DONE;
  - an amount-width helper.
- Sub-module `shifter_step`: purely combinational, shifts a `SIZE`-bit word by k ∈ 0…`SHIFTVAL` in a given mode. It is instantiated once in the SHIFT datapath.

## Test plan
- SLL, `in_data`=0x0000_0001, amt 5, accepted at N → `out_data`=0x0000_0020, `out_valid` first high at N+4.
- SRA, 0x8000_0000, amt 31 → 0xFFFF_FFFF at N+17; SRL with the same operands → 0x0000_0001.
- Any mode, 0x1234_5678, amt 0 → 0x1234_5678 at N+1.
- Mode 11, 0x0000_00F1, amt 4:
  - with `ITER_SHIFTER_ROR_EN` → 0x1000_000F;
  - without it → 0x0000_000F.
- Backpressure:
  - `out_ready` held low for 10 cycles in DONE → `out_valid`/`out_data` stable and `in_ready`=0.
  - A new `in_valid` pulse during this window is ignored.
  - After `out_ready`, `in_ready`=1 on the next cycle.
- Assert `rst` during SHIFT of amt 20 → `out_valid` never rises. The next request, SLL 0x3 amt 2, returns 0x0000_000C at N+2.
